alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares the single combinational ALU between two requesters (0 = main pipeline, 1 = address/aux unit).
//  Round-robin arbitration, valid/ready request and response channels, two-stage pipeline: operand reg (S1) -> result reg (S2).
//  Sits between the requesters and the ALU instance and drives the ALU's A/B/opcode inputs from S1.
// PARAMETERS
//  DATA_W  32  operand/result width (signed two's complement)
//  OP_W    5   ALU opcode width
// PORTS
//  clk            in   1       single clock, rising edge
//  rst_n          in   1       synchronous reset, active-low
//  req_valid      in   2       per-requester request valid
//  req_ready      out  2       per-requester request accepted this cycle
//  req_a          in   2*DATA_W  operand A; requester i in bits [i*DATA_W +: DATA_W]
//  req_b          in   2*DATA_W  operand B, same packing
//  req_op         in   2*OP_W    ALU opcode, same packing
//  rsp_valid      out  2       result for requester i valid
//  rsp_ready      in   2       requester i takes result
//  rsp_data       out  DATA_W  result (shared bus; qualified by rsp_valid)
//  alu_a          out  DATA_W  to ALU_A_in
//  alu_b          out  DATA_W  to ALU_B_in
//  alu_op         out  OP_W    to ALU opcode
//  alu_out        in   DATA_W  from ALUOut
//  busy           out  1       S1 or S2 occupied
// BEHAVIOUR
//  Reset (rst_n=0 at edge): s1_valid=s2_valid=0, rr pointer=0 (req 0 favoured), all S1/S2 data regs=0.
//   Outputs during/after reset: req_ready=0, rsp_valid=0, rsp_data=0, alu_a/b/op=0, busy=0.
//  Reset mid-operation drops in-flight ops silently; no response is produced for them.
//  Arbitration (comb): if both valid, grant req[ptr]; else grant the sole valid one; none -> no grant.
//   ptr <= ~granted_id on every accepted request; ptr unchanged when nothing accepted.
//  Pipeline advance: s2_free = !s2_valid | rsp_ready[s2_id]; s1_adv = s1_valid & s2_free;
//   can_accept = !s1_valid | s1_adv.
//  req_ready[i] = grant[i] & can_accept; at most one bit set. req_ready may depend on req_valid.
//  Accept (req_valid[i] & req_ready[i]): S1 <= {a, b, op, id=i}, s1_valid<=1.
//  S1 -> ALU: alu_a/alu_b/alu_op driven from S1 regs while s1_valid, else all zero.
//  s1_adv: S2 <= {alu_out, s1_id}, s2_valid<=1. S1 cleared unless refilled same cycle.
//  rsp_valid[i] = s2_valid & (s2_id==i); rsp_data = S2 data (0 when !s2_valid).
//  S2 drains when rsp_ready[s2_id]=1; rsp_ready of the other requester is ignored.
//  Latency: accept at edge k -> ALU inputs valid after k -> rsp_valid after edge k+1 (2 cycles), no stall.
//  Throughput: 1 op/cycle with rsp_ready held high; back-to-back requests from both alternate 0,1,0,1.
//  Stall: S2 held, S1 held if full, req_ready=0; all held data stable. Response order == accept order.
//  Simultaneous S2 drain + S1 advance + new accept in the same cycle is legal and required.
//  Opcode is passed through unchecked; the ALU defines semantics (unknown op -> ADD).
//  Arithmetic: no width change; result is alu_out captured verbatim (wraps mod 2^DATA_W).
//  busy = s1_valid | s2_valid.
// TESTING (bench instantiates real ALU)
//  1 Reset: hold rst_n=0 3 cycles with req_valid=2'b11 -> req_ready=0, rsp_valid=0, alu_*=0, busy=0.
//  2 Single op: req0 A=10 B=3 op=5'b00010 (SUB) -> req_ready[0]=1 one cycle; 2 cycles later rsp_valid=01, rsp_data=7.
//  3 Contention: both valid every cycle, req0 ADD 1+1, req1 ASR -16>>>2, rsp_ready=11 -> grants 0,1,0,1; data 2, -4 alternating.
//  4 Backpressure: req1 OR 0xF0|0x0F, rsp_ready[1]=0 for 4 cycles -> rsp_data=0xFF held stable, S1 fills, req_ready=0 after; release -> drain in order.
//  5 Wrap: ADD 0x7FFFFFFF+1 -> 0x80000000; SL 1<<31 -> 0x80000000; NOT 0 -> 0xFFFFFFFF.
//  6 Reset mid-flight: accept 2 ops, assert rst_n=0 with S1,S2 full -> no rsp_valid after reset, ptr=0, busy=0.

Source files
------------

// File: rtl/alu_share_if.sv
// Request/response and ALU-side bundle for the shared ALU arbiter.
// Requester i uses bits [i*DATA_W +: DATA_W] of req_a/req_b and [i*OP_W +: OP_W] of req_op.
interface alu_share_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
) ();
  logic        [1:0]          req_valid;
  logic        [1:0]          req_ready;
  logic        [2*DATA_W-1:0] req_a;
  logic        [2*DATA_W-1:0] req_b;
  logic        [2*OP_W-1:0]   req_op;
  logic        [1:0]          rsp_valid;
  logic        [1:0]          rsp_ready;
  logic signed [DATA_W-1:0]   rsp_data;
  logic signed [DATA_W-1:0]   alu_a;
  logic signed [DATA_W-1:0]   alu_b;
  logic        [OP_W-1:0]     alu_op;
  logic signed [DATA_W-1:0]   alu_out;
  logic                       busy;

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready, alu_out,
    output req_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_op, busy
  );

  // Requester / ALU side
  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready, alu_out,
    input  req_ready, rsp_valid, rsp_data, alu_a, alu_b, alu_op, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Two-stage pipeline: operand register (p1) feeds the ALU, result register (p2)
// holds the response until the owning requester takes it.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_share_if.slave   bus
);

  logic                     ptr;
  logic                     vld_p1;
  logic                     id_p1;
  logic signed [DATA_W-1:0] a_p1;
  logic signed [DATA_W-1:0] b_p1;
  logic        [OP_W-1:0]   op_p1;
  logic                     vld_p2;
  logic                     id_p2;
  logic signed [DATA_W-1:0] res_p2;

  logic        [1:0]        grant;
  logic                     s2_free;
  logic                     s1_adv;
  logic                     can_accept;
  logic                     accept;
  logic                     acc_id;
  logic signed [DATA_W-1:0] sel_a;
  logic signed [DATA_W-1:0] sel_b;
  logic        [OP_W-1:0]   sel_op;

  // Grant the favoured requester on contention, otherwise whichever one is asking
  always_comb begin
    grant = 2'b00;
    if (&bus.req_valid) begin
      grant = ptr ? 2'b10 : 2'b01;
    end else begin
      grant = bus.req_valid;
    end
  end

  assign s2_free    = !vld_p2 || bus.rsp_ready[id_p2];
  assign s1_adv     = vld_p1 && s2_free;
  assign can_accept = !vld_p1 || s1_adv;

  // Held low while in reset so nothing looks accepted during the reset window
  assign bus.req_ready = (rst_n && can_accept) ? grant : 2'b00;
  assign accept        = |bus.req_ready;
  assign acc_id        = bus.req_ready[1];

  assign sel_a  = acc_id ? bus.req_a[2*DATA_W-1:DATA_W] : bus.req_a[DATA_W-1:0];
  assign sel_b  = acc_id ? bus.req_b[2*DATA_W-1:DATA_W] : bus.req_b[DATA_W-1:0];
  assign sel_op = acc_id ? bus.req_op[2*OP_W-1:OP_W]    : bus.req_op[OP_W-1:0];

  // Pointer, operand stage and result stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr    <= 1'b0;
      vld_p1 <= 1'b0;
      id_p1  <= 1'b0;
      a_p1   <= '0;
      b_p1   <= '0;
      op_p1  <= '0;
      vld_p2 <= 1'b0;
      id_p2  <= 1'b0;
      res_p2 <= '0;
    end else begin
      if (accept) begin
        ptr <= ~acc_id;
      end

      // request -> p1: capture the granted operands
      if (accept) begin
        vld_p1 <= 1'b1;
        id_p1  <= acc_id;
        a_p1   <= sel_a;
        b_p1   <= sel_b;
        op_p1  <= sel_op;
      end else if (s1_adv) begin
        vld_p1 <= 1'b0;
      end

      // p1 -> p2: capture the ALU result verbatim
      if (s1_adv) begin
        vld_p2 <= 1'b1;
        id_p2  <= id_p1;
        res_p2 <= bus.alu_out;
      end else if (s2_free) begin
        vld_p2 <= 1'b0;
      end
    end
  end

  assign bus.alu_a  = vld_p1 ? a_p1  : '0;
  assign bus.alu_b  = vld_p1 ? b_p1  : '0;
  assign bus.alu_op = vld_p1 ? op_p1 : '0;

  assign bus.rsp_valid = vld_p2 ? (id_p2 ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_data  = vld_p2 ? res_p2 : '0;
  assign bus.busy      = vld_p1 | vld_p2;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a behavioural ALU, table-driven single ops,
// directed multi-cycle sequences and a randomized run against a queue model.
module tb_alu_share_arbiter;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_AND = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4;
  localparam logic [4:0] OP_SL  = 5'd5;
  localparam logic [4:0] OP_SR  = 5'd6;
  localparam logic [4:0] OP_ASR = 5'd7;
  localparam logic [4:0] OP_NOT = 5'd8;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  alu_share_if #(.DATA_W(32), .OP_W(5)) bus ();

  alu_share_arbiter #(.DATA_W(32), .OP_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the real ALU; unknown opcodes behave as ADD
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_AND:  return a & b;
      OP_SUB:  return a - b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SL:   return a << b[4:0];
      OP_SR:   return a >> b[4:0];
      OP_ASR:  return $signed(a) >>> b[4:0];
      OP_NOT:  return ~a;
      default: return a + b;
    endcase
  endfunction

  assign bus.alu_out = alu_f(bus.alu_a, bus.alu_b, bus.alu_op);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic id, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (id) begin
      bus.req_a[63:32] = a;
      bus.req_b[63:32] = b;
      bus.req_op[9:5]  = op;
    end else begin
      bus.req_a[31:0]  = a;
      bus.req_b[31:0]  = b;
      bus.req_op[4:0]  = op;
    end
  endtask

  // Reference model: in-flight ops in accept order, each tagged with its accept cycle
  typedef struct {
    logic        id;
    logic [31:0] data;
    int          cyc;
  } ent_t;

  ent_t q[$];
  int   cur;
  logic last_id;
  logic mon_en;

  always @(negedge clk) begin
    logic [1:0]  exp_rv;
    logic [1:0]  exp_rdy;
    logic [1:0]  acc;
    logic        can;
    logic        aid;
    ent_t        e;
    if (mon_en) begin
      check("rnd_busy", 32'(bus.busy), 32'(q.size() != 0));
      exp_rv = 2'b00;
      if (q.size() != 0 && q[0].cyc < cur) exp_rv = q[0].id ? 2'b10 : 2'b01;
      check("rnd_rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
      if (exp_rv != 2'b00) check("rnd_rsp_data", bus.rsp_data, q[0].data);
      // Two ops in flight means the oldest sits in the result stage
      can = (q.size() < 2) || bus.rsp_ready[q[0].id];
      if (!can) exp_rdy = 2'b00;
      else if (&bus.req_valid) exp_rdy = last_id ? 2'b01 : 2'b10;
      else exp_rdy = bus.req_valid;
      check("rnd_req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      if (exp_rv != 2'b00 && (bus.rsp_ready & exp_rv) != 2'b00) void'(q.pop_front());
      acc = bus.req_valid & bus.req_ready;
      if (acc != 2'b00) begin
        aid    = (acc == 2'b10);
        e.id   = aid;
        e.data = aid ? alu_f(bus.req_a[63:32], bus.req_b[63:32], bus.req_op[9:5])
                     : alu_f(bus.req_a[31:0],  bus.req_b[31:0],  bus.req_op[4:0]);
        e.cyc  = cur + 1;
        q.push_back(e);
        last_id = aid;
      end
      cur++;
    end
  end

  typedef struct {
    logic        id;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    mon_en    = 1'b0;
    cur       = 0;
    last_id   = 1'b1;
    rst_n     = 1'b0;
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b00;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;

    vecs[0] = '{1'b0, OP_SUB, 32'd10,         32'd3,  32'd7};
    vecs[1] = '{1'b0, OP_ADD, 32'h7FFF_FFFF,  32'd1,  32'h8000_0000};
    vecs[2] = '{1'b1, OP_SL,  32'd1,          32'd31, 32'h8000_0000};
    vecs[3] = '{1'b0, OP_NOT, 32'd0,          32'd0,  32'hFFFF_FFFF};
    vecs[4] = '{1'b1, OP_ASR, 32'hFFFF_FFF0,  32'd2,  32'hFFFF_FFFC};
    vecs[5] = '{1'b1, OP_OR,  32'h0000_00F0,  32'h0F, 32'h0000_00FF};
    vecs[6] = '{1'b0, 5'd31,  32'd5,          32'd6,  32'd11};
    vecs[7] = '{1'b1, OP_SUB, 32'd0,          32'd1,  32'hFFFF_FFFF};

    // Reset held with both requesters asking
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_data",  bus.rsp_data, 32'd0);
      check("rst_alu_a",     bus.alu_a, 32'd0);
      check("rst_alu_b",     bus.alu_b, 32'd0);
      check("rst_alu_op",    32'(bus.alu_op), 32'd0);
      check("rst_busy",      32'(bus.busy), 32'd0);
    end
    rst_n = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    cyc();

    // Single ops from the table, each run alone through the pipeline
    for (int i = 0; i < 8; i++) begin
      set_req(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
      bus.req_valid = vecs[i].id ? 2'b10 : 2'b01;
      #1;
      check("vec_req_ready", 32'(bus.req_ready), 32'(bus.req_valid));
      cyc();
      bus.req_valid = 2'b00;
      #1;
      check("vec_alu_a",  bus.alu_a, vecs[i].a);
      check("vec_alu_b",  bus.alu_b, vecs[i].b);
      check("vec_alu_op", 32'(bus.alu_op), 32'(vecs[i].op));
      check("vec_rsp_early", 32'(bus.rsp_valid), 32'd0);
      cyc();
      check("vec_rsp_valid", 32'(bus.rsp_valid), vecs[i].id ? 32'd2 : 32'd1);
      check("vec_rsp_data",  bus.rsp_data, vecs[i].exp);
      cyc();
      check("vec_idle_busy", 32'(bus.busy), 32'd0);
      check("vec_idle_rsp",  32'(bus.rsp_valid), 32'd0);
    end

    // Contention: both ask every cycle, grants must alternate starting with 0
    set_req(1'b0, OP_ADD, 32'd1, 32'd1);
    set_req(1'b1, OP_ASR, 32'hFFFF_FFF0, 32'd2);
    bus.rsp_ready = 2'b11;
    for (int n = 0; n < 8; n++) begin
      bus.req_valid = (n < 6) ? 2'b11 : 2'b00;
      #1;
      if (n < 6) check("cont_req_ready", 32'(bus.req_ready), (n % 2 == 1) ? 32'd2 : 32'd1);
      if (n >= 2) begin
        check("cont_rsp_valid", 32'(bus.rsp_valid), (n % 2 == 1) ? 32'd2 : 32'd1);
        check("cont_rsp_data",  bus.rsp_data, (n % 2 == 1) ? 32'hFFFF_FFFC : 32'd2);
      end
      cyc();
    end
    check("cont_busy_end", 32'(bus.busy), 32'd0);

    // Backpressure on requester 1's response channel
    bus.rsp_ready = 2'b01;
    set_req(1'b1, OP_OR, 32'h0F0, 32'h00F);
    bus.req_valid = 2'b10;
    #1;
    check("bp_ready0", 32'(bus.req_ready), 32'd2);
    cyc();
    set_req(1'b1, OP_OR, 32'h100, 32'h001);
    #1;
    check("bp_ready1", 32'(bus.req_ready), 32'd2);
    cyc();
    set_req(1'b1, OP_OR, 32'h1000, 32'h2000);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("bp_stall_ready", 32'(bus.req_ready), 32'd0);
      check("bp_stall_rsp",   32'(bus.rsp_valid), 32'd2);
      check("bp_stall_data",  bus.rsp_data, 32'h0FF);
      check("bp_stall_alu_a", bus.alu_a, 32'h100);
      check("bp_stall_busy",  32'(bus.busy), 32'd1);
      cyc();
    end
    bus.rsp_ready = 2'b11;
    #1;
    check("bp_release_ready", 32'(bus.req_ready), 32'd2);
    check("bp_release_data",  bus.rsp_data, 32'h0FF);
    cyc();
    bus.req_valid = 2'b00;
    #1;
    check("bp_order1_valid", 32'(bus.rsp_valid), 32'd2);
    check("bp_order1_data",  bus.rsp_data, 32'h101);
    cyc();
    check("bp_order2_data",  bus.rsp_data, 32'h3000);
    cyc();
    check("bp_busy_end", 32'(bus.busy), 32'd0);

    // Reset while both stages are full
    bus.rsp_ready = 2'b00;
    set_req(1'b0, OP_ADD, 32'd5, 32'd5);
    bus.req_valid = 2'b01;
    #1;
    check("mid_ready0", 32'(bus.req_ready), 32'd1);
    cyc();
    check("mid_ready1", 32'(bus.req_ready), 32'd1);
    cyc();
    bus.req_valid = 2'b11;
    #1;
    check("mid_full_busy",  32'(bus.busy), 32'd1);
    check("mid_full_rsp",   32'(bus.rsp_valid), 32'd1);
    check("mid_full_ready", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b0;
    cyc();
    check("mid_rst_busy",  32'(bus.busy), 32'd0);
    check("mid_rst_rsp",   32'(bus.rsp_valid), 32'd0);
    check("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    check("mid_rst_alu_a", bus.alu_a, 32'd0);
    cyc();
    rst_n = 1'b1;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("mid_after_rsp",  32'(bus.rsp_valid), 32'd0);
      check("mid_after_busy", 32'(bus.busy), 32'd0);
    end
    bus.req_valid = 2'b11;
    #1;
    check("mid_ptr_reset", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 2'b00;

    // Randomized traffic against the queue model
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n   = 1'b1;
    q.delete();
    cur     = 0;
    last_id = 1'b1;
    mon_en  = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      logic [4:0] op0;
      logic [4:0] op1;
      op0 = 5'($urandom_range(0, 12));
      op1 = 5'($urandom_range(0, 12));
      bus.req_valid = 2'($urandom_range(0, 3));
      bus.req_a     = {$urandom(), $urandom()};
      bus.req_b     = {$urandom(), $urandom()};
      bus.req_op    = {op1, op0};
      bus.rsp_ready = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      cyc();
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b11;
    for (int n = 0; n < 6; n++) cyc();
    mon_en = 1'b0;
    check("rnd_drain_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
